// File: rtl/riscv_instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_instr_stream_encoder
// Purpose  : Encodes high-level instruction commands into RV32 words (incl.
//            custom AES opcode 7'h3b), buffers them in a small FIFO and
//            serves them on a req/gnt/rvalid instruction-fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_instr_stream_encoder #(
  parameter int DEPTH   = 4,
  parameter bit PAD_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_kind_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [2:0]  cmd_funct3_i,
  input  logic [6:0]  cmd_funct7_i,
  input  logic [19:0] cmd_imm_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        jump_o,
  output logic        err_o,
  output logic [15:0] issued_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   C_NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] C_KIND_OP      = 3'd0;
  localparam logic [2:0] C_KIND_OPIMM   = 3'd1;
  localparam logic [2:0] C_KIND_LOAD    = 3'd2;
  localparam logic [2:0] C_KIND_STORE   = 3'd3;
  localparam logic [2:0] C_KIND_LUI     = 3'd4;
  localparam logic [2:0] C_KIND_AES     = 3'd5;
  localparam logic [2:0] C_KIND_NOP     = 3'd6;
  localparam logic [2:0] C_KIND_ILLEGAL = 3'd7;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          jump_q, jump_d;
  logic          err_q, err_d;
  logic [15:0]   issued_q, issued_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic          have_last_q, have_last_d;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push;
  logic          w_gnt;
  logic          w_pop;
  logic [31:0]   w_word;

  // Translate the command fields into a 32-bit instruction word.
  always_comb begin
    w_word = C_NOP_WORD;
    case (cmd_kind_i)
      C_KIND_OP:    w_word = {cmd_funct7_i, cmd_rs2_i, cmd_rs1_i, cmd_funct3_i, cmd_rd_i, 7'h33};
      C_KIND_OPIMM: w_word = {cmd_imm_i[11:0], cmd_rs1_i, cmd_funct3_i, cmd_rd_i, 7'h13};
      C_KIND_LOAD:  w_word = {cmd_imm_i[11:0], cmd_rs1_i, cmd_funct3_i, cmd_rd_i, 7'h03};
      C_KIND_STORE: w_word = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, cmd_funct3_i,
                              cmd_imm_i[4:0], 7'h23};
      C_KIND_LUI:   w_word = {cmd_imm_i[19:0], cmd_rd_i, 7'h37};
      C_KIND_AES:   w_word = {cmd_funct7_i, cmd_rs2_i, cmd_rs1_i, cmd_funct3_i, cmd_rd_i, 7'h3b};
      C_KIND_NOP:   w_word = C_NOP_WORD;
      default:      w_word = C_NOP_WORD;
    endcase
  end

  // Handshake decode; ready ignores a same-cycle pop, grant is blocked in reset/flush.
  always_comb begin
    w_full      = (count_q == C_FULL_CNT);
    w_empty     = (count_q == '0);
    cmd_ready_o = !w_full && !flush_i;
    w_accept    = cmd_valid_i && cmd_ready_o;
    w_push      = w_accept && (cmd_kind_i != C_KIND_ILLEGAL);
    w_gnt       = rst_n && instr_req_i && !flush_i && (!w_empty || PAD_NOP);
    w_pop       = w_gnt && !w_empty;
    instr_gnt_o = w_gnt;
  end

  // Next-state for FIFO storage, pointers, response and tracking registers.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rvalid_d    = w_gnt;
    rdata_d     = rdata_q;
    jump_d      = w_gnt && have_last_q && (instr_addr_i != (last_addr_q + 32'd4));
    err_d       = err_q || (w_accept && (cmd_kind_i == C_KIND_ILLEGAL));
    issued_d    = w_gnt ? (issued_q + 16'd1) : issued_q;
    last_addr_d = w_gnt ? instr_addr_i : last_addr_q;
    have_last_d = have_last_q || w_gnt;

    if (w_gnt) begin
      rdata_d = w_empty ? C_NOP_WORD : mem_q[rd_ptr_q];
    end
    if (w_push) begin
      mem_d[wr_ptr_q] = w_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flush discards everything buffered and restarts jump tracking.
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      have_last_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      jump_q      <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= '0;
      last_addr_q <= '0;
      have_last_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      jump_q      <= jump_d;
      err_q       <= err_d;
      issued_q    <= issued_d;
      last_addr_q <= last_addr_d;
      have_last_q <= have_last_d;
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign jump_o         = jump_q;
  assign err_o          = err_q;
  assign issued_cnt_o   = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_instr_stream_encoder
// Purpose  : Scoreboard bench; primary instance pads with NOP, a second
//            instance (PAD_NOP=0) covers the waiting-fetch behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_stream_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid_np = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [19:0] imm = '0;
  logic        req = 1'b0;
  logic        req_np = 1'b0;
  logic [31:0] addr = '0;

  logic        ready, gnt, rvalid, jump, err;
  logic [31:0] rdata;
  logic [15:0] cnt;
  logic        ready_np, gnt_np, rvalid_np, jump_np, err_np;
  logic [31:0] rdata_np;
  logic [15:0] cnt_np;

  riscv_instr_stream_encoder #(.DEPTH(DEPTH), .PAD_NOP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(ready), .cmd_kind_i(kind),
    .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
    .cmd_funct3_i(f3), .cmd_funct7_i(f7), .cmd_imm_i(imm),
    .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
    .jump_o(jump), .err_o(err), .issued_cnt_o(cnt)
  );

  riscv_instr_stream_encoder #(.DEPTH(DEPTH), .PAD_NOP(1'b0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid_np), .cmd_ready_o(ready_np), .cmd_kind_i(kind),
    .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
    .cmd_funct3_i(f3), .cmd_funct7_i(f7), .cmd_imm_i(imm),
    .instr_req_i(req_np), .instr_addr_i(addr), .instr_gnt_o(gnt_np),
    .instr_rvalid_o(rvalid_np), .instr_rdata_o(rdata_np),
    .jump_o(jump_np), .err_o(err_np), .issued_cnt_o(cnt_np)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        jmp;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] cmd_word = '0;
  logic        m_err = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_addr = '0;
  logic [15:0] m_cnt = '0;
  int          np_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a response is due and checks idle cycles.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rvalid", {31'd0, rvalid}, 32'd1);
      chk("rdata", rdata, e.data);
      chk("jump", {31'd0, jump}, {31'd0, e.jmp});
    end else begin
      chk("rvalid_idle", {31'd0, rvalid}, 32'd0);
      chk("jump_idle", {31'd0, jump}, 32'd0);
    end
  end

  task automatic set_cmd(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                         input logic [19:0] im, input logic [31:0] w);
    kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im; cmd_word = w;
  endtask

  // One clock cycle: check handshakes against the model, record expectations, advance.
  task automatic tick();
    logic er, eg, ern, egn;
    exp_t e;
    #1;
    er  = !flush && (model_q.size() < DEPTH);
    eg  = req && !flush;                      // primary instance always pads when empty
    ern = !flush && (np_cnt < DEPTH);
    egn = req_np && !flush && (np_cnt > 0);
    chk("cmd_ready", {31'd0, ready}, {31'd0, er});
    chk("instr_gnt", {31'd0, gnt}, {31'd0, eg});
    chk("cmd_ready_np", {31'd0, ready_np}, {31'd0, ern});
    chk("instr_gnt_np", {31'd0, gnt_np}, {31'd0, egn});
    if (eg) begin
      if (model_q.size() > 0) e.data = model_q.pop_front();
      else                    e.data = NOP;
      e.jmp = have_last && (addr != last_addr + 32'd4);
      e.due = cyc + 1;
      exp_q.push_back(e);
      last_addr = addr;
      have_last = 1'b1;
      m_cnt     = m_cnt + 16'd1;
    end
    if (egn) np_cnt--;
    if (flush) begin
      model_q.delete();
      have_last = 1'b0;
      np_cnt    = 0;
    end
    if (cmd_valid && er) begin
      if (kind == 3'd7) m_err = 1'b1;
      else              model_q.push_back(cmd_word);
    end
    if (cmd_valid_np && ern && kind != 3'd7) np_cnt++;
    @(posedge clk);
    #1;
    chk("issued_cnt", {16'd0, cnt}, {16'd0, m_cnt});
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic reset_checks();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_gnt_np", {31'd0, gnt_np}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_jump", {31'd0, jump}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
  endtask

  initial begin
    // Reset, with a fetch request held to prove the grant is masked.
    req = 1'b1;
    @(posedge clk); #1;
    reset_checks();
    @(posedge clk); #1;
    req = 1'b0; rst_n = 1'b1;

    // OPIMM addi x1,x0,5 (upper imm bits must be ignored); fetch at 0x80.
    set_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'hFF005, 32'h0050_0093);
    cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    req = 1'b1; addr = 32'h80; tick(); req = 1'b0; tick();

    // Fill the FIFO: AES, STORE (rd field ignored), LUI (rs1 ignored), OP.
    cmd_valid = 1'b1;
    set_cmd(3'd5, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0, 32'h0020_81BB);      tick();
    set_cmd(3'd3, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0, 20'd8, 32'h0020_A423);     tick();
    set_cmd(3'd4, 5'd5, 5'd7, 5'd0, 3'd0, 7'd0, 20'h12345, 32'h1234_52B7);  tick();
    set_cmd(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 20'd0, 32'h4031_00B3);     tick();
    // LOAD held while full: refused, also refused in the draining cycle, then taken.
    set_cmd(3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 20'h00010, 32'h0101_2203);  tick();
    req = 1'b1; addr = 32'h84; tick();
    addr = 32'h88; tick();
    cmd_valid = 1'b0;
    addr = 32'h8C; tick();
    addr = 32'h90; tick();
    addr = 32'h94; tick();
    // Empty FIFO: jump to 0x100 pads NOP, then three sequential pad fetches.
    addr = 32'h100; tick();
    addr = 32'h104; tick();
    addr = 32'h108; tick();
    addr = 32'h10C; tick();
    req = 1'b0;

    // Illegal command: handshake completes, nothing queued, sticky error.
    set_cmd(3'd7, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 20'd1, 32'd0);
    cmd_valid = 1'b1; tick();
    // Explicit NOP command, fetched with a jump.
    set_cmd(3'd6, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 20'd1, NOP);
    tick(); cmd_valid = 1'b0;
    req = 1'b1; addr = 32'h200; tick(); req = 1'b0; tick();

    // Non-padding instance: fetch waits on an empty FIFO until a command lands.
    req_np = 1'b1; addr = 32'h0;
    tick(); tick(); tick();
    set_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd5, 32'h0050_0093);
    cmd_valid_np = 1'b1; tick(); cmd_valid_np = 1'b0;
    tick();
    chk("np_rvalid", {31'd0, rvalid_np}, 32'd1);
    chk("np_rdata", rdata_np, 32'h0050_0093);
    req_np = 1'b0; tick();

    // Flush with three entries buffered; afterwards the non-padding fetch waits.
    cmd_valid = 1'b1; cmd_valid_np = 1'b1;
    tick(); tick(); tick();
    cmd_valid = 1'b0; cmd_valid_np = 1'b0;
    flush = 1'b1; req = 1'b1; req_np = 1'b1; addr = 32'h300; tick();
    flush = 1'b0; addr = 32'h400; tick();
    chk("np_wait_after_flush", {31'd0, gnt_np}, 32'd0);
    req_np = 1'b0;

    // Reset while a response is owed: it must be dropped.
    addr = 32'h404; tick();
    chk("owed_rvalid", {31'd0, rvalid}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete(); model_q.delete();
    m_cnt = '0; m_err = 1'b0; have_last = 1'b0; np_cnt = 0;
    #1;
    reset_checks();
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_instr_stream_encoder.md
# riscv_instr_stream_encoder

Encodes high-level instruction commands into 32-bit RV32 instruction words, including the custom AES opcode 7'h3b. It buffers them in a small FIFO and serves them to the core's instruction-fetch port as a fetch responder (req/gnt/rvalid). It sits between a test or boot sequencer and the RI5CY instruction interface, in place of instruction memory. It is the encode/serve counterpart of the core's decoder.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PAD_NOP, 1: when 1, a fetch against an empty FIFO is granted and returns NOP 32'h00000013; when 0, the fetch waits.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all FIFO contents.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_kind_i  in  3  0 OP, 1 OPIMM, 2 LOAD, 3 STORE, 4 LUI, 5 AES, 6 NOP, 7 illegal.
- cmd_rd_i, cmd_rs1_i, cmd_rs2_i  in  5 each  register indices.
- cmd_funct3_i  in  3;  cmd_funct7_i  in  7;  cmd_imm_i  in  20  immediate (low 12 bits for I/S types).
- instr_req_i  in  1;  instr_addr_i  in  32  fetch request from the core.
- instr_gnt_o  out  1  combinational grant.
- instr_rvalid_o  out  1;  instr_rdata_o  out  32  response data.
- jump_o  out  1  one-cycle pulse when a granted address is not the previous granted address + 4.
- err_o  out  1  sticky; set by an accepted illegal command.
- issued_cnt_o  out  16  count of granted fetches, including pad NOPs; wraps.

## Operation
- Encoding per accepted command (opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20]):
  - OP: {funct7, rs2, rs1, funct3, rd, 7'h33}.
  - OPIMM: {imm[11:0], rs1, funct3, rd, 7'h13}.
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'h03}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'h23}.
  - LUI: {imm[19:0], rd, 7'h37}.
  - AES: {funct7, rs2, rs1, funct3, rd, 7'h3b}.
  - NOP: 32'h00000013.
- Kind 7: the command is accepted (handshake completes) but nothing is pushed; err_o is set and stays set until reset.
- FIFO: cmd_ready_o = !full. ready does not depend on a same-cycle pop, so a full FIFO does not accept while draining.
- Grant: instr_gnt_o = instr_req_i & (!empty | PAD_NOP). A grant pops the head, or selects NOP if empty.
- Response: the cycle after a grant, instr_rvalid_o = 1 and instr_rdata_o holds the registered word. rdata holds its last value while rvalid is 0.
- Back-to-back grants are allowed: one grant and one rvalid per cycle.
- Address tracking:
  - Register last_addr on each grant.
  - jump_o pulses in the cycle after a grant whose address ≠ last_addr + 4.
  - The first grant after reset or flush never pulses jump_o.
  - The address never alters data.
- Flush:
  - Empties the FIFO and clears jump tracking.
  - flush_i also suppresses cmd acceptance and grant in that cycle (cmd_ready_o = 0, instr_gnt_o = 0).
  - A rvalid already owed from the prior cycle's grant is still delivered.

## Timing
- Reset values:
  - cmd_ready_o 1, because the FIFO is empty.
  - instr_gnt_o forced 0 while rst_n is low.
  - instr_rvalid_o 0, instr_rdata_o 0, jump_o 0, err_o 0, issued_cnt_o 0.
- Reset asserted mid-transfer drops any owed rvalid.
- Latency: a command accepted at edge N is grantable in cycle N+1, and its rvalid comes in cycle N+2 at the earliest. There is no push-to-pop bypass.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy counts 0..DEPTH.
- issued_cnt_o increments at each grant edge and wraps 16'hFFFF → 0.

## Test plan
- OPIMM, rd=1, rs1=0, funct3=0, imm=5; then a fetch at 0x80 -> gnt in the cycle after accept; rvalid next cycle with rdata 0x00500093; issued_cnt_o = 1.
- AES rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> rdata 0x002081BB. STORE rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423. LUI rd=5, imm=0x12345 -> 0x123452B7.
- Fill 4 commands with no fetches -> cmd_ready_o 0 while full; one grant -> ready returns to 1 the next cycle; data comes out in FIFO order.
- PAD_NOP=1 with an empty FIFO and req high for 3 cycles -> 3 grants and 3 rvalids, each with 0x00000013. PAD_NOP=0 -> gnt stays 0 until a command arrives.
- Fetch addresses 0x80, 0x84, 0x100 -> jump_o pulses only for 0x100. kind=7 -> ready handshake completes, no FIFO entry, err_o = 1.
- Fill 3 entries, assert flush_i -> the next fetch with PAD_NOP=0 waits. Assert rst_n low during an owed rvalid -> rvalid 0, all outputs at reset values.
